// File: rtl/game_io_pkg.sv
// ----------------------------------------------------------------------------
// game_io_pkg
// Shared definitions for the game I/O blocks (buttons, light_up, audio).
//   - Colour codes, common to every block that names a button or lamp.
//   - Bit positions inside the 32-bit button read word.
//   - MMIO address of the button read word.
//   - pack_read_word(): builds the read word from its fields.
// ----------------------------------------------------------------------------
package game_io_pkg;

  localparam int NUM_BUTTONS = 4;

  localparam logic [1:0] COLOR_RED    = 2'b00;
  localparam logic [1:0] COLOR_BLUE   = 2'b01;
  localparam logic [1:0] COLOR_GREEN  = 2'b10;
  localparam logic [1:0] COLOR_YELLOW = 2'b11;

  localparam int VALID_BIT = 0;
  localparam int COLOR_LSB = 1;
  localparam int OVF_BIT   = 3;
  localparam int REL_BIT   = 4;

  localparam logic [11:0] BUTTON_ADDR = 12'd7;

  // Colour and release flag are only meaningful alongside a valid entry, so
  // they are forced to zero when the queue is empty.
  function automatic logic [31:0] pack_read_word(input logic       valid,
                                                 input logic [1:0] color,
                                                 input logic       ovf,
                                                 input logic       rel);
    logic [31:0] word;
    word                 = '0;
    word[VALID_BIT]      = valid;
    word[COLOR_LSB +: 2] = valid ? color : 2'b00;
    word[OVF_BIT]        = ovf;
    word[REL_BIT]        = valid & rel;
    return word;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
// Synchronizes one asynchronous raw button and debounces it. The debounced
// level only changes after the synchronized level has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; shorter glitches are ignored.
// SYNC_STAGES must be at least 2.
//
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high reset (level returns to released)
//   raw    in   raw button input, active high, asynchronous
//   level  out  debounced button level
// ----------------------------------------------------------------------------
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;

  assign synced = sync_q[SYNC_STAGES-1];
  assign level  = level_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, as real hardware does.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (synced == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// ----------------------------------------------------------------------------
// button_event_queue
// Front end of the memory-mapped button read (address 7). Debounces the four
// game buttons, turns clean presses into colour events, queues them in a
// small FIFO and presents the oldest one on the CPU read word while the CPU
// polls. The head is popped at the end of each poll window.
//
// Optional build macro: BUTTON_RELEASE_EVENTS_EN -- debounced releases also
// queue events (bit 4 set), arbitrated below all presses.
//
// Ports:
//   clock          in   system clock (50 MHz)
//   reset          in   synchronous, active-high reset
//   red_button     in   raw button, active high, asynchronous
//   yellow_button  in   raw button, active high, asynchronous
//   blue_button    in   raw button, active high, asynchronous
//   green_button   in   raw button, active high, asynchronous
//   poll_button    in   high while the CPU data address equals 7
//   button_out     out  read word: [0] valid, [2:1] colour, [3] overflow,
//                       [4] release flag, [31:5] zero
// ----------------------------------------------------------------------------
module button_event_queue #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        red_button,
  input  logic        yellow_button,
  input  logic        blue_button,
  input  logic        green_button,
  input  logic        poll_button,
  output logic [31:0] button_out
);

  import game_io_pkg::*;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef BUTTON_RELEASE_EVENTS_EN
  localparam int ENTRY_W = 3;   // {release, colour}
`else
  localparam int ENTRY_W = 2;   // {colour}
`endif

  // Button vectors are indexed by colour code, so a lower index is also a
  // higher arbitration priority (red > blue > green > yellow).
  logic [NUM_BUTTONS-1:0] raw;
  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] level_prev;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] press_pend;
  logic [NUM_BUTTONS-1:0] press_grant;

  logic                   enq;
  logic [ENTRY_W-1:0]     enq_entry;

  logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic                   ovf;
  logic                   poll_prev;

  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   do_pop;
  logic                   do_push;
  logic                   drop;
  logic [ENTRY_W-1:0]     head;
  logic                   head_rel;

  assign raw = {yellow_button, green_button, blue_button, red_button};

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_deb
    button_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clock (clock),
      .reset (reset),
      .raw   (raw[g]),
      .level (level[g])
    );
  end

  assign rise = level & ~level_prev;

`ifdef BUTTON_RELEASE_EVENTS_EN
  logic [NUM_BUTTONS-1:0] fall;
  logic [NUM_BUTTONS-1:0] release_pend;
  logic [NUM_BUTTONS-1:0] release_grant;

  assign fall = ~level & level_prev;
`endif

  // Arbiter: at most one event per cycle, presses before releases.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    press_grant = '0;
    enq         = 1'b0;
    enq_entry   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!enq && press_pend[i]) begin
        enq            = 1'b1;
        press_grant[i] = 1'b1;
        enq_entry[1:0] = 2'(i);
      end
    end
`ifdef BUTTON_RELEASE_EVENTS_EN
    release_grant = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!enq && release_pend[i]) begin
        enq              = 1'b1;
        release_grant[i] = 1'b1;
        enq_entry        = {1'b1, 2'(i)};
      end
    end
`endif
  end

  // A pop on an empty queue is ignored; a pop frees a full slot in time for
  // an enqueue in the same cycle.
  assign pop     = poll_prev & ~poll_button;
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = enq & (~full | do_pop);
  assign drop    = enq & ~do_push;

  always_ff @(posedge clock) begin
    if (reset) begin
      level_prev <= '0;
      press_pend <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      poll_prev  <= 1'b0;
    end else begin
      level_prev <= level;
      // The granted flag clears even when the event is dropped on a full queue.
      press_pend <= (press_pend & ~press_grant) | rise;
      poll_prev  <= poll_button;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop)       ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
    end
  end

`ifdef BUTTON_RELEASE_EVENTS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      release_pend <= '0;
    end else begin
      release_pend <= (release_pend & ~release_grant) | fall;
    end
  end
`endif

  // NOTE: the storage array has no reset; count alone decides which entries
  // are valid, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= enq_entry;
  end

  assign head = mem[rd_ptr];
`ifdef BUTTON_RELEASE_EVENTS_EN
  assign head_rel = head[2];
`else
  assign head_rel = 1'b0;
`endif

  assign button_out = poll_button ? pack_read_word(~empty, head[1:0], ovf, head_rel)
                                  : 32'h0;

endmodule

// File: tb/tb_button_event_queue.sv
// ----------------------------------------------------------------------------
// tb_button_event_queue
// Directed bench for button_event_queue with DEBOUNCE_CYCLES = 4,
// SYNC_STAGES = 2, FIFO_DEPTH = 4. Inputs change just after a rising edge,
// button_out is sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_button_event_queue;

  logic        clock         = 1'b0;
  logic        reset         = 1'b1;
  logic        red_button    = 1'b0;
  logic        yellow_button = 1'b0;
  logic        blue_button   = 1'b0;
  logic        green_button  = 1'b0;
  logic        poll_button   = 1'b0;
  logic [31:0] button_out;

  int total = 0;
  int bad   = 0;

`ifdef BUTTON_RELEASE_EVENTS_EN
  localparam logic [31:0] REL_BLUE   = 32'h13;
  localparam logic [31:0] REL_GREEN  = 32'h15;
  localparam logic [31:0] REL_RED    = 32'h11;
  localparam logic [31:0] REL_YELLOW = 32'h17;
`else
  localparam logic [31:0] REL_BLUE   = 32'h0;
  localparam logic [31:0] REL_GREEN  = 32'h0;
  localparam logic [31:0] REL_RED    = 32'h0;
  localparam logic [31:0] REL_YELLOW = 32'h0;
`endif

  always #5 clock = ~clock;

  button_event_queue #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .FIFO_DEPTH      (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .red_button    (red_button),
    .yellow_button (yellow_button),
    .blue_button   (blue_button),
    .green_button  (green_button),
    .poll_button   (poll_button),
    .button_out    (button_out)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    @(negedge clock);
    total++;
    assert (button_out === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, button_out, expected);
    end
  endtask

  // One poll window of n cycles; the head pops on the edge after it closes.
  task automatic poll(input string tag, input int n, input logic [31:0] expected);
    poll_button = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, expected);
      next_cycle();
    end
    poll_button = 1'b0;
    next_cycle();
  endtask

  // b = {yellow, green, blue, red}: hold long enough to press, then release.
  task automatic press_release(input logic [3:0] b);
    {yellow_button, green_button, blue_button, red_button} = b;
    wait_cycles(10);
    {yellow_button, green_button, blue_button, red_button} = 4'b0000;
    wait_cycles(10);
  endtask

  initial begin
    // Reset hold: three reset edges with blue high and poll high.
    reset       = 1'b1;
    blue_button = 1'b1;
    poll_button = 1'b1;
    wait_cycles(2);
    check("reset_hold", 32'h0);
    next_cycle();
    reset = 1'b0;
    // Blue is in the queue exactly 2 + 4 + 2 = 8 edges after reset release.
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      check($sformatf("reset_latency_%0d", k), (k == 8) ? 32'h3 : 32'h0);
    end
    blue_button = 1'b0;
    poll_button = 1'b0;
    next_cycle();
    wait_cycles(12);
    poll("blue_release", 1, REL_BLUE);

    // Glitch reject: three cycles high is one short of the debounce time.
    red_button = 1'b1;
    wait_cycles(3);
    red_button = 1'b0;
    wait_cycles(10);
    poll("glitch", 2, 32'h0);

    // Single held press: one event, stable for the whole window.
    green_button = 1'b1;
    wait_cycles(20);
    poll("single", 3, 32'h5);
    poll("single_again", 1, 32'h0);
    green_button = 1'b0;
    wait_cycles(12);
    poll("green_release", 1, REL_GREEN);

    // Simultaneous press: red wins, yellow follows.
    red_button    = 1'b1;
    yellow_button = 1'b1;
    wait_cycles(12);
    poll("sim_first", 1, 32'h1);
    poll("sim_second", 1, 32'h7);
    poll("sim_empty", 1, 32'h0);
    red_button    = 1'b0;
    yellow_button = 1'b0;
    wait_cycles(12);
    poll("sim_rel_red", 1, REL_RED);
    poll("sim_rel_yellow", 1, REL_YELLOW);

`ifndef BUTTON_RELEASE_EVENTS_EN
    // Overflow: fifth press is dropped and flags overflow.
    press_release(4'b0001);
    press_release(4'b0010);
    press_release(4'b0100);
    press_release(4'b1000);
    press_release(4'b0001);
    poll("ovf_red", 1, 32'h9);
    poll("ovf_blue", 1, 32'h3);
    poll("ovf_green", 1, 32'h5);
    poll("ovf_yellow", 1, 32'h7);
    poll("ovf_empty", 1, 32'h0);

    // Reset mid-queue: two queued events vanish.
    press_release(4'b0001);
    press_release(4'b0010);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    poll("reset_mid_queue", 1, 32'h0);

    // Reset mid-debounce: partial press never becomes an event.
    green_button = 1'b1;
    wait_cycles(4);
    reset = 1'b1;
    next_cycle();
    reset        = 1'b0;
    green_button = 1'b0;
    wait_cycles(12);
    poll("reset_mid_debounce", 1, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
